// File: rtl/osnt_sume_10g_rx_latency_probe.sv
// RX latency probe: zero-latency AXI-Stream pass-through that extracts the TX timestamp/signature
// words per packet, reports latency and tracks sequence loss/reorder. Optional min/max: RX_LAT_MINMAX_EN.
//   state   | meaning
//   ST_SOP  | waiting for / accepting the first beat of a packet
//   ST_BODY | accepting the remaining beats until tlast
module osnt_sume_10g_rx_latency_probe #(
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_DATA_WIDTH  = 64,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int TS_WIDTH             = 64
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     rx_ts_pos,
  input  logic [TS_WIDTH-1:0]               timestamp_156,
  input  logic                              clear,
  output logic                              lat_valid,
  output logic [TS_WIDTH-1:0]               lat_value,
  output logic [31:0]                       lat_seq,
  output logic [31:0]                       rx_pkt_count,
  output logic [31:0]                       sig_pkt_count,
  output logic [31:0]                       lost_count,
  output logic [31:0]                       reorder_count
`ifdef RX_LAT_MINMAX_EN
  ,
  output logic [TS_WIDTH-1:0]               lat_min,
  output logic [TS_WIDTH-1:0]               lat_max
`endif
);

  localparam logic [31:0] SIG_WORD = 32'hefbeadde;
  localparam int          PW       = C_S_AXI_DATA_WIDTH;

  typedef enum logic {ST_SOP, ST_BODY} state_t;

  state_t              state_q, state_d;
  logic [15:0]         wcnt_q;
  logic [TS_WIDTH-1:0] rx_time_q;
  logic [TS_WIDTH-1:0] tx_time_q;
  logic                ts_seen_q;
  logic                sig_ok_q;
  logic [31:0]         seq_q;
  logic [31:0]         exp_q;
  logic                armed_q;

  logic                beat_acc;
  logic                is_sop;
  logic                pos_en;
  logic [PW:0]         pos_p1;
  logic [PW:0]         wcnt_ext;
  logic                ts_hit;
  logic                ts_seen_eff;
  logic                sig_hit;
  logic                sig_ok_eff;
  logic [31:0]         seq_eff;
  logic                pkt_done;
  logic                sig_done;
  logic [31:0]         seq_diff;
  logic [TS_WIDTH-1:0] lat_calc;

  // Pure pass-through; the probe never back-pressures the MAC.
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tlast  = s_axis_tlast;
  assign s_axis_tready = m_axis_tready;

  assign beat_acc = s_axis_tvalid & m_axis_tready;
  assign is_sop   = (state_q == ST_SOP);
  assign pos_en   = |rx_ts_pos;
  assign pos_p1   = {1'b0, rx_ts_pos} + {{PW{1'b0}}, 1'b1};
  assign wcnt_ext = (PW+1)'(wcnt_q);

  // Per-packet flags from earlier beats are ignored on the SOP beat.
  assign ts_seen_eff = ts_seen_q & ~is_sop;
  assign ts_hit      = beat_acc & pos_en & (wcnt_ext == {1'b0, rx_ts_pos});
  assign sig_hit     = beat_acc & pos_en & ts_seen_eff & (wcnt_ext == pos_p1) &
                       (s_axis_tdata[31:0] == SIG_WORD);
  assign sig_ok_eff  = sig_hit | (sig_ok_q & ~is_sop);
  assign seq_eff     = sig_hit ? s_axis_tdata[63:32] : seq_q;
  assign pkt_done    = beat_acc & s_axis_tlast;
  assign sig_done    = pkt_done & sig_ok_eff;
  assign seq_diff    = seq_eff - exp_q;
  assign lat_calc    = rx_time_q - tx_time_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) state_q <= ST_SOP;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SOP:  if (beat_acc && !s_axis_tlast) state_d = ST_BODY;
      ST_BODY: if (beat_acc && s_axis_tlast)  state_d = ST_SOP;
      default: state_d = ST_SOP;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wcnt_q    <= 16'd1;
      rx_time_q <= '0;
      tx_time_q <= '0;
      ts_seen_q <= 1'b0;
      sig_ok_q  <= 1'b0;
      seq_q     <= '0;
    end else if (beat_acc) begin
      if (s_axis_tlast)           wcnt_q <= 16'd1;
      else if (wcnt_q != 16'hffff) wcnt_q <= wcnt_q + 16'd1;
      if (is_sop) rx_time_q <= timestamp_156;
      if (ts_hit) tx_time_q <= s_axis_tdata[TS_WIDTH-1:0];
      ts_seen_q <= ts_hit | ts_seen_eff;
      sig_ok_q  <= sig_ok_eff;
      if (sig_hit) seq_q <= s_axis_tdata[63:32];
    end
  end

  // Result registers are not touched by clear so an in-flight packet is still reported.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      lat_valid <= 1'b0;
      lat_value <= '0;
      lat_seq   <= '0;
    end else begin
      lat_valid <= sig_done;
      if (sig_done) begin
        lat_value <= lat_calc;
        lat_seq   <= seq_eff;
      end
    end
  end

  // Counters and sequence tracker; clear takes priority over any update.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      rx_pkt_count  <= '0;
      sig_pkt_count <= '0;
      lost_count    <= '0;
      reorder_count <= '0;
      exp_q         <= '0;
      armed_q       <= 1'b0;
    end else if (clear) begin
      rx_pkt_count  <= '0;
      sig_pkt_count <= '0;
      lost_count    <= '0;
      reorder_count <= '0;
      armed_q       <= 1'b0;
    end else begin
      if (pkt_done) rx_pkt_count <= rx_pkt_count + 32'd1;
      if (sig_done) begin
        sig_pkt_count <= sig_pkt_count + 32'd1;
        if (!armed_q) begin
          armed_q <= 1'b1;
          exp_q   <= seq_eff + 32'd1;
        end else if (!seq_diff[31]) begin
          lost_count <= lost_count + seq_diff;
          exp_q      <= seq_eff + 32'd1;
        end else begin
          reorder_count <= reorder_count + 32'd1;
        end
      end
    end
  end

`ifdef RX_LAT_MINMAX_EN
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      lat_min <= '1;
      lat_max <= '0;
    end else if (clear) begin
      lat_min <= '1;
      lat_max <= '0;
    end else if (sig_done) begin
      if (lat_calc < lat_min) lat_min <= lat_calc;
      if (lat_calc > lat_max) lat_max <= lat_calc;
    end
  end
`endif

endmodule

// File: doc/osnt_sume_10g_rx_latency_probe.md
Name: osnt_sume_10g_rx_latency_probe

Overview:
Receive-side counterpart of the 10G TX queue's timestamp/signature stamping. Sits between the 10G MAC RX stream and the monitoring pipeline and passes AXI-Stream traffic through unchanged. On each packet it locates the 64-bit TX timestamp word at word position rx_ts_pos and the {seq[31:0], 32'hefbeadde} signature word at rx_ts_pos+1. From these it produces a per-packet latency result, tracks sequence loss and reordering, and keeps statistics counters.

Parameters:
C_M_AXIS_DATA_WIDTH, 64, output stream data width (only 64 supported)
C_S_AXIS_DATA_WIDTH, 64, input stream data width (only 64 supported)
C_M_AXIS_TUSER_WIDTH, 128, output tuser width
C_S_AXIS_TUSER_WIDTH, 128, input tuser width
C_S_AXI_DATA_WIDTH, 32, width of the rx_ts_pos control input
TS_WIDTH, 64, timestamp and latency width

Ports:
axis_aclk  in  1  sole clock
axis_resetn  in  1  asynchronous active-low reset
s_axis_tdata/tkeep/tuser/tvalid/tlast  in  64/8/128/1/1  RX stream from the MAC
s_axis_tready  out  1  equals m_axis_tready (combinational)
m_axis_tdata/tkeep/tuser/tvalid/tlast  out  64/8/128/1/1  combinational copy of s_axis_*
m_axis_tready  in  1  downstream ready
rx_ts_pos  in  32  1-based word index of the timestamp word; 0 disables extraction
timestamp_156  in  64  free-running local time
clear  in  1  synchronous clear of all statistics and the sequence tracker
lat_valid  out  1  one-cycle pulse when a result is available
lat_value  out  64  rx_time - tx_time, modulo 2^64
lat_seq  out  32  sequence number of that packet
rx_pkt_count  out  32  packets seen (tlast handshakes)
sig_pkt_count  out  32  packets with a matching signature
lost_count  out  32  accumulated sequence gaps
reorder_count  out  32  packets whose seq is below the expected value

Behaviour:
- Handshake: a beat is accepted when s_axis_tvalid & m_axis_tready; all parsing acts on accepted beats only. The block never stalls the stream.
- Word counter wcnt is 1-based and set to 1 on the first beat of each packet. It increments per accepted beat and saturates at 2^16-1.
- FSM states:
  - SOP:
    - On accepting a beat, sample timestamp_156 into rx_time.
    - If tlast is also set, finish the packet (see below) and stay in SOP.
    - Otherwise go to BODY.
  - BODY:
    - Accept beats and go to SOP on an accepted tlast.
- Capture: on the accepted beat with wcnt==rx_ts_pos, tx_time is loaded with tdata and ts_seen is set. On the accepted beat with wcnt==rx_ts_pos+1, the block checks tdata[31:0]==32'hefbeadde. On a match it latches seq=tdata[63:32] and sets sig_ok.
- rx_ts_pos==0 means no capture, so sig_ok stays 0. ts_seen and sig_ok are cleared on every SOP.
- Finishing a packet (the cycle of the accepted tlast beat, including when tlast falls on the signature word):
  - rx_pkt_count increments.
  - If sig_ok (counting the same-cycle match), then on the next cycle:
    - lat_valid is 1.
    - lat_value = rx_time - tx_time (64-bit wrap).
    - lat_seq = seq.
    - sig_pkt_count increments.
- Sequence tracker, for sig_ok packets only:
  - First packet after reset or clear: arms the tracker and sets exp = seq+1.
  - seq==exp: exp <= seq+1.
  - diff = seq-exp interpreted as signed 32-bit:
    - diff>0: lost_count += diff, exp <= seq+1.
    - diff<0: reorder_count++, exp unchanged.
- Packets that end before the signature word, or carry a bad signature: counted in rx_pkt_count only. No lat_valid and no tracker update.
- Counters wrap at 2^32.
- clear: zeroes all counters and disarms the tracker. It does not affect the FSM, capture registers or an in-flight packet. If clear coincides with an increment, clear wins. The in-flight packet finishing later is still reported.
- Reset values, all applied asynchronously:
  - FSM=SOP.
  - lat_valid=0, lat_value=0, lat_seq=0.
  - All counters 0, tracker disarmed.
  - m_axis_* follow s_axis_*.
- Latency: pass-through 0 cycles. Result 1 cycle after the tlast handshake.

Optional Feature:
Macro RX_LAT_MINMAX_EN.
- Defined:
  - Adds outputs lat_min and lat_max (64 bits each).
  - Reset values: lat_min=all ones, lat_max=0.
  - Updated with each lat_valid result; reset by clear.
- Undefined: the ports and logic are absent.

Test Plan:
- rx_ts_pos=2, 8-word packet, word2=64'd1000, word3=64'h00000001_efbeadde, timestamp_156=1500 at SOP -> lat_valid pulse 1 cycle after tlast, lat_value=500, lat_seq=1, sig_pkt_count=1, rx_pkt_count=1.
- Seqs 1,2,5,3 -> lost_count=2, reorder_count=1, four lat_valid pulses.
- Bad signature 64'h00000007_deadbeef, then a 2-word packet with rx_ts_pos=2 -> rx_pkt_count=2, sig_pkt_count=0, no lat_valid.
- tx_time=64'hFFFF_FFFF_FFFF_FFF0 with rx_time=64'h10 -> lat_value=64'h20. Random m_axis_tready backpressure gives identical results.
- clear asserted mid-packet on the tlast cycle -> counters 0, packet still reported via lat_valid. Next sig packet re-arms the tracker with no lost_count.
- rx_ts_pos=0, 10 packets -> rx_pkt_count=10, no lat_valid. axis_resetn low mid-packet -> all outputs at reset values immediately, FSM restarts at next SOP.
